// File: rtl/oto_pilot_ctrl_if.sv
// oto_pilot_ctrl_if
//   Sensor-sample / command bundle between the mprj_io sensor front end and
//   the altitude-hold controller.
//   Parameter:
//     W                    altitude width in bits
//   Signals:
//     gnss_i               GNSS altitude, unsigned
//     altimetre_i          altimeter altitude, unsigned
//     hedef_yukseklik_i    target altitude, unsigned
//     yukseklik_bilgisi_i  sample valid
//     komut_o              one-hot command (001 CLIMB, 010 DESCEND, 100 HOLD, 000 IDLE/FAULT)
//     karar_gecerli_o      one-cycle decision strobe
//     fault_o              sensor-disagreement fault latched
//   Modports:
//     master  sensor side (drives samples, receives commands)
//     slave   controller side
interface oto_pilot_ctrl_if #(
  parameter int W = 6
);
  logic [W-1:0] gnss_i;
  logic [W-1:0] altimetre_i;
  logic [W-1:0] hedef_yukseklik_i;
  logic         yukseklik_bilgisi_i;
  logic [2:0]   komut_o;
  logic         karar_gecerli_o;
  logic         fault_o;

  modport master (
    output gnss_i, altimetre_i, hedef_yukseklik_i, yukseklik_bilgisi_i,
    input  komut_o, karar_gecerli_o, fault_o
  );

  modport slave (
    input  gnss_i, altimetre_i, hedef_yukseklik_i, yukseklik_bilgisi_i,
    output komut_o, karar_gecerli_o, fault_o
  );
endinterface

// File: rtl/oto_pilot_ctrl.sv
// oto_pilot_ctrl
//   Altitude-hold controller. Fuses GNSS and altimeter altitude, compares the
//   fused value with the target through a +/-HYST dead band and issues a
//   one-hot climb/descend/hold command. A command change is accepted only
//   after the new proposal persists for PERSIST consecutive samples.
//   Pipeline: capture (edge N) -> fusion/proposal (edge N+1) -> FSM and
//   registered command/strobe (edge N+2).
//   Ports:
//     wb_clk_i   single clock
//     wb_rst_i   synchronous active-high reset
//     bus        oto_pilot_ctrl_if.slave (samples in, command/strobe/fault out)
//   Build option:
//     OTO_PILOT_FAULT_EN  when defined, samples whose |gnss - altimetre|
//                         exceeds DISAGREE fall back to the altimeter, and
//                         FAULT_LIM consecutive such samples latch a sticky
//                         FAULT state. Undefined: plain average, fault_o = 0.
module oto_pilot_ctrl #(
  parameter int W         = 6,
  parameter int HYST      = 1,
  parameter int PERSIST   = 3,
  parameter int DISAGREE  = 4,
  parameter int FAULT_LIM = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  oto_pilot_ctrl_if.slave   bus
);

  localparam int STAGES = 2;

  // State encodings double as the command code; FAULT is masked to 000.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_CLIMB = 3'b001,
    ST_DESC  = 3'b010,
    ST_HOLD  = 3'b100,
    ST_FAULT = 3'b111
  } state_t;

  localparam logic signed [W:0] HYST_P    = (W+1)'(HYST);
  localparam logic signed [W:0] HYST_N    = -HYST_P;
  localparam logic [3:0]        PERSIST_C = 4'(PERSIST);

  if (W < 2 || W > 16 || PERSIST < 1 || PERSIST > 15 ||
      FAULT_LIM < 1 || FAULT_LIM > 15 || DISAGREE < 0) begin : g_param_chk
    $error("oto_pilot_ctrl: parameter out of range");
  end

  // vld_pipe[0]: captured sample, [1]: proposal ready, [2]: decision strobe
  logic [STAGES:0] vld_pipe;
  logic [W-1:0]    s1_gnss, s1_alt, s1_tgt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) vld_pipe <= '0;
    else          vld_pipe <= {vld_pipe[STAGES-1:0], bus.yukseklik_bilgisi_i};
  end

  always_ff @(posedge wb_clk_i) begin
    if (bus.yukseklik_bilgisi_i) begin
      s1_gnss <= bus.gnss_i;
      s1_alt  <= bus.altimetre_i;
      s1_tgt  <= bus.hedef_yukseklik_i;
    end
  end

  // ---------------- fusion and proposal ----------------
  logic [W:0]          sum;
  logic [W-1:0]        fused;
  logic signed [W:0]   err;
  state_t              prop;
  state_t              s2_prop;

`ifdef OTO_PILOT_FAULT_EN
  logic [W-1:0] diff;
  logic         dis;
  logic         s2_dis;
`endif

  always_comb begin
    sum   = {1'b0, s1_gnss} + {1'b0, s1_alt};
    fused = W'(sum >> 1);
`ifdef OTO_PILOT_FAULT_EN
    diff  = (s1_gnss >= s1_alt) ? s1_gnss - s1_alt : s1_alt - s1_gnss;
    dis   = 32'(diff) > DISAGREE;
    // Sensors disagree: trust the altimeter alone.
    if (dis) fused = s1_alt;
`endif
    err = $signed({1'b0, s1_tgt}) - $signed({1'b0, fused});
    if (err > HYST_P)      prop = ST_CLIMB;
    else if (err < HYST_N) prop = ST_DESC;
    else                   prop = ST_HOLD;
  end

  always_ff @(posedge wb_clk_i) begin
    if (vld_pipe[0]) begin
      s2_prop <= prop;
`ifdef OTO_PILOT_FAULT_EN
      s2_dis  <= dis;
`endif
    end
  end

  // ---------------- decision FSM ----------------
  state_t     state, state_nxt;
  state_t     prev, prev_nxt;
  logic [3:0] pcnt, pcnt_nxt, pcnt_inc;
  logic [2:0] komut_q;

`ifdef OTO_PILOT_FAULT_EN
  localparam logic [3:0] FLIM_C = 4'(FAULT_LIM);
  logic [3:0] fcnt, fcnt_nxt;
  logic       fault_q;
`endif

  always_comb begin
    state_nxt = state;
    prev_nxt  = s2_prop;
    pcnt_nxt  = pcnt;
    pcnt_inc  = '0;
    unique case (state)
      ST_IDLE: begin
        // First decision adopts the proposal without persistence.
        state_nxt = s2_prop;
        pcnt_nxt  = '0;
      end
      ST_FAULT: ;
      default: begin
        if (s2_prop == state) begin
          pcnt_nxt = '0;
        end else begin
          // A run of identical proposals grows the count; a new one restarts at 1.
          if (s2_prop == prev)
            pcnt_inc = (pcnt >= PERSIST_C) ? PERSIST_C : pcnt + 4'd1;
          else
            pcnt_inc = 4'd1;
          if (pcnt_inc >= PERSIST_C) begin
            state_nxt = s2_prop;
            pcnt_nxt  = '0;
          end else begin
            pcnt_nxt  = pcnt_inc;
          end
        end
      end
    endcase
`ifdef OTO_PILOT_FAULT_EN
    fcnt_nxt = s2_dis ? ((fcnt >= FLIM_C) ? FLIM_C : fcnt + 4'd1) : 4'd0;
    if (fcnt_nxt >= FLIM_C) begin
      state_nxt = ST_FAULT;
      pcnt_nxt  = '0;
    end
`endif
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= ST_IDLE;
      prev    <= ST_IDLE;
      pcnt    <= '0;
      komut_q <= '0;
`ifdef OTO_PILOT_FAULT_EN
      fcnt    <= '0;
      fault_q <= 1'b0;
`endif
    end else if (vld_pipe[1]) begin
      state   <= state_nxt;
      prev    <= prev_nxt;
      pcnt    <= pcnt_nxt;
      komut_q <= (state_nxt == ST_FAULT) ? 3'b000 : state_nxt;
`ifdef OTO_PILOT_FAULT_EN
      fcnt    <= fcnt_nxt;
      fault_q <= (state_nxt == ST_FAULT);
`endif
    end
  end

  assign bus.komut_o         = komut_q;
  assign bus.karar_gecerli_o = vld_pipe[STAGES];
`ifdef OTO_PILOT_FAULT_EN
  assign bus.fault_o         = fault_q;
`else
  assign bus.fault_o         = 1'b0;
`endif

endmodule

// File: tb/tb_oto_pilot_ctrl.sv
// tb_oto_pilot_ctrl
//   Directed bench for oto_pilot_ctrl. u_dut uses default parameters,
//   u_p1 uses PERSIST = 1 for the dead-band steps. Expectations follow the
//   build option seen by the bench (OTO_PILOT_FAULT_EN on or off).
module tb_oto_pilot_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  oto_pilot_ctrl_if #(.W(6)) bd ();
  oto_pilot_ctrl_if #(.W(6)) bp ();

  oto_pilot_ctrl u_dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bd.slave));
  oto_pilot_ctrl #(.PERSIST(1)) u_p1 (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bp.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_in(input bit p1, input logic [5:0] g, input logic [5:0] a,
                        input logic [5:0] t, input logic v);
    if (p1) begin
      bp.gnss_i = g; bp.altimetre_i = a; bp.hedef_yukseklik_i = t; bp.yukseklik_bilgisi_i = v;
    end else begin
      bd.gnss_i = g; bd.altimetre_i = a; bd.hedef_yukseklik_i = t; bd.yukseklik_bilgisi_i = v;
    end
  endtask

  function automatic logic [2:0] komut(input bit p1);
    return p1 ? bp.komut_o : bd.komut_o;
  endfunction
  function automatic logic strobe(input bit p1);
    return p1 ? bp.karar_gecerli_o : bd.karar_gecerli_o;
  endfunction
  function automatic logic fault(input bit p1);
    return p1 ? bp.fault_o : bd.fault_o;
  endfunction

  // One sample captured at edge N; strobe must be low after N+1 and high
  // after N+2, with the expected command and fault flag.
  task automatic step(input bit p1, input logic [5:0] g, input logic [5:0] a,
                      input logic [5:0] t, input logic [2:0] ek, input logic ef,
                      input string tag);
    @(negedge clk); set_in(p1, g, a, t, 1'b1);
    @(negedge clk); set_in(p1, g, a, t, 1'b0);
    @(posedge clk); #1;
    chk({tag, " strobe_n1"}, strobe(p1), 1'b0);
    @(posedge clk); #1;
    chk({tag, " strobe_n2"}, strobe(p1), 1'b1);
    chk({tag, " komut"}, komut(p1), ek);
    chk({tag, " fault"}, fault(p1), ef);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk({tag, " komut"}, bd.komut_o, 3'b000);
    chk({tag, " strobe"}, bd.karar_gecerli_o, 1'b0);
    chk({tag, " fault"}, bd.fault_o, 1'b0);
    chk({tag, " p1_komut"}, bp.komut_o, 3'b000);
  endtask

  initial begin
    set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
    set_in(1'b1, 6'd0, 6'd0, 6'd0, 1'b0);
    repeat (2) @(posedge clk);
    do_reset("reset");

    // First decision: fused 12, err 35 -> CLIMB, strobe exactly at N+2.
    step(1'b0, 6'd13, 6'd12, 6'd47, 3'b001, 1'b0, "first");
    @(posedge clk); #1;
    chk("first strobe_n3", bd.karar_gecerli_o, 1'b0);
    chk("first komut_hold", bd.komut_o, 3'b001);

    // Persistence: 47,47,40,47,47,47 -> CLIMB x5 then HOLD.
    step(1'b0, 6'd47, 6'd47, 6'd47, 3'b001, 1'b0, "pers1");
    step(1'b0, 6'd47, 6'd47, 6'd47, 3'b001, 1'b0, "pers2");
    step(1'b0, 6'd40, 6'd40, 6'd47, 3'b001, 1'b0, "pers3");
    step(1'b0, 6'd47, 6'd47, 6'd47, 3'b001, 1'b0, "pers4");
    step(1'b0, 6'd47, 6'd47, 6'd47, 3'b001, 1'b0, "pers5");
    step(1'b0, 6'd47, 6'd47, 6'd47, 3'b100, 1'b0, "pers6");

    // Dead band with PERSIST = 1, target 30.
    do_reset("reset_hyst");
    step(1'b1, 6'd31, 6'd31, 6'd30, 3'b100, 1'b0, "hyst31");
    step(1'b1, 6'd29, 6'd29, 6'd30, 3'b100, 1'b0, "hyst29");
    step(1'b1, 6'd32, 6'd32, 6'd30, 3'b010, 1'b0, "hyst32");
    step(1'b1, 6'd28, 6'd28, 6'd30, 3'b001, 1'b0, "hyst28");

    do_reset("reset_fault");
`ifdef OTO_PILOT_FAULT_EN
    // Disagreeing samples fall back to altimetre 20 -> HOLD; an agreeing
    // sample clears the count, so the fault needs 4 fresh disagreements.
    step(1'b0, 6'd40, 6'd20, 6'd20, 3'b100, 1'b0, "dis1");
    step(1'b0, 6'd40, 6'd20, 6'd20, 3'b100, 1'b0, "dis2");
    step(1'b0, 6'd40, 6'd20, 6'd20, 3'b100, 1'b0, "dis3");
    step(1'b0, 6'd20, 6'd20, 6'd20, 3'b100, 1'b0, "agree_clr");
    step(1'b0, 6'd40, 6'd20, 6'd20, 3'b100, 1'b0, "dis1b");
    step(1'b0, 6'd40, 6'd20, 6'd20, 3'b100, 1'b0, "dis2b");
    step(1'b0, 6'd40, 6'd20, 6'd20, 3'b100, 1'b0, "dis3b");
    step(1'b0, 6'd40, 6'd20, 6'd20, 3'b000, 1'b1, "dis4_fault");
    step(1'b0, 6'd20, 6'd20, 6'd20, 3'b000, 1'b1, "fault_sticky1");
    step(1'b0, 6'd10, 6'd10, 6'd40, 3'b000, 1'b1, "fault_sticky2");
`else
    // Without the fault feature the plain average 30 is used -> HOLD.
    for (int i = 0; i < 5; i++)
      step(1'b0, 6'd40, 6'd20, 6'd30, 3'b100, 1'b0, "avg_hold");
`endif
    do_reset("reset_after_fault");

    // Reset one cycle after a valid sample discards it.
    step(1'b0, 6'd10, 6'd10, 6'd47, 3'b001, 1'b0, "pre_rst");
    @(negedge clk); set_in(1'b0, 6'd40, 6'd40, 6'd10, 1'b1);
    @(negedge clk); set_in(1'b0, 6'd40, 6'd40, 6'd10, 1'b0); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst strobe", bd.karar_gecerli_o, 1'b0);
    chk("midrst komut", bd.komut_o, 3'b000);
    @(posedge clk); #1;
    chk("midrst strobe2", bd.karar_gecerli_o, 1'b0);

    // Reset and valid on the same edge: reset wins.
    @(negedge clk); set_in(1'b0, 6'd40, 6'd40, 6'd10, 1'b1); rst = 1'b1;
    @(negedge clk); set_in(1'b0, 6'd40, 6'd40, 6'd10, 1'b0); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("samerst strobe", bd.karar_gecerli_o, 1'b0);
    end

    // FSM back in IDLE: next decision jumps straight to DESCEND.
    step(1'b0, 6'd40, 6'd40, 6'd10, 3'b010, 1'b0, "idle_jump");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/oto_pilot_ctrl.md
# oto_pilot_ctrl

Parametrised altitude-hold controller for the autopilot user project. It is the next generation of the fixed 6-bit autopilot core and sits inside `user_project_wrapper`, fed from the mprj_io sensor pins. It fuses GNSS and altimeter altitude, compares the result against the target altitude with a hysteresis band, and issues a one-hot climb/descend/hold command. A command change takes effect only after it has persisted for a set number of samples. Optionally, it detects sensor disagreement and latches a fault.

## Interface
Parameters:
- `W`, 6: altitude width in bits, 2..16.
- `HYST`, 1: dead-band half-width, unsigned, less than 2^W.
- `PERSIST`, 3: consecutive identical proposals required to change command, 1..15.
- `DISAGREE`, 4: maximum allowed |gnss−altimetre| before a sample counts as disagreeing.
- `FAULT_LIM`, 4: consecutive disagreeing samples that latch a fault, 1..15.

Ports:
- `wb_clk_i`, in, 1: the single clock.
- `wb_rst_i`, in, 1: reset, synchronous, active-high.
- `gnss_i`, in, W: GNSS altitude, unsigned.
- `altimetre_i`, in, W: altimeter altitude, unsigned.
- `hedef_yukseklik_i`, in, W: target altitude, unsigned.
- `yukseklik_bilgisi_i`, in, 1: sample-valid; the three inputs are captured on every clock edge where this is high.
- `komut_o`, out, 3: command, one-hot. 3'b001 = CLIMB, 3'b010 = DESCEND, 3'b100 = HOLD, 3'b000 = IDLE or FAULT.
- `karar_gecerli_o`, out, 1: one-cycle strobe marking a decision for a sample.
- `fault_o`, out, 1: fault latched.

## Operation
- **Stage 1 (capture).** On a valid edge, register all three inputs plus a valid bit.
- **Stage 2 (fusion).**
  - `sum` is W+1 bits; `fused = sum >> 1` (floor).
  - `diff = |gnss − altimetre|`, W bits.
  - With the fault feature, a sample with diff > DISAGREE is disagreeing, and `fused = altimetre`.
- **Error.** `err = target − fused`, signed W+1 bits.
- **Proposal.**
  - CLIMB if err > HYST.
  - DESCEND if err < −HYST.
  - Otherwise HOLD. err = ±HYST gives HOLD.
- **FSM states:** IDLE, HOLD, CLIMB, DESCEND, FAULT.
  - IDLE: the first decision jumps directly to the proposal, with no persistence.
  - HOLD/CLIMB/DESCEND, proposal equals current state: persistence counter cleared.
  - HOLD/CLIMB/DESCEND, proposal differs from the current state and equals the previous proposal: counter increments. When the counter reaches PERSIST, the FSM moves to the proposal and the counter clears.
  - HOLD/CLIMB/DESCEND, proposal differs from both the current state and the previous proposal: counter becomes 1.
  - PERSIST = 1 means immediate switching.
- **Fault counting.**
  - Each disagreeing sample increments the fault counter; an agreeing sample clears it.
  - When the counter reaches FAULT_LIM, the FSM goes to FAULT (overriding the proposal) and `fault_o` is set.
  - FAULT is sticky until reset. Strobes still pulse in FAULT, and `komut_o` stays 000.
- **No valid sample:** all state and counters hold.
- **Reset values:** `komut_o` = 000, `karar_gecerli_o` = 0, `fault_o` = 0, FSM = IDLE, all counters and pipeline valid bits = 0.

## Timing
- **Latency.** A sample valid at edge N produces `komut_o`/`karar_gecerli_o` at edge N+2. `komut_o` is registered and changes only together with a strobe.
- **Throughput.** Fully pipelined: valid may be high every cycle, giving one decision per cycle. Back-to-back samples each count separately toward PERSIST and FAULT_LIM.
- **Reset mid-operation.** Reset wins over valid on the same edge. In-flight samples are discarded: no strobe follows a reset for samples captured before it.
- **Counter widths.** Counters saturate and never wrap. The persistence counter is 4 bits and stops at PERSIST; the fault counter stops at FAULT_LIM.

## Configuration
- **`OTO_PILOT_FAULT_EN` defined:** disagreement detection, altimeter fallback, the fault counter and the FAULT state are present.
- **`OTO_PILOT_FAULT_EN` undefined:**
  - Fused altitude is always the average.
  - `fault_o` is tied 0 and FAULT is unreachable.
  - DISAGREE and FAULT_LIM are ignored.

## Test plan
All scenarios use default parameters and the macro defined unless stated.
- **First decision.** Reset, then target 47, gnss 13, altimetre 12, valid for one cycle. Fused = 12, err = 35. Expect `komut_o` = 001 and a strobe exactly 2 cycles later.
- **Persistence.** From CLIMB with target 47, feed fused values 47, 47, 40, 47, 47, 47. Expect CLIMB held through the 5th decision and HOLD (100) on the 6th.
- **Hysteresis.** Target 30, PERSIST = 1, fused 31 → HOLD. Fused 29 → HOLD. Fused 32 → DESCEND (010). Fused 28 → CLIMB.
- **Fault.** gnss 40, altimetre 20, target 20, for 3 samples: expect HOLD (fused = 20). On the 4th sample: `fault_o` = 1 and `komut_o` = 000. Then agreeing samples: both outputs stay latched until reset.
- **Reset mid-operation.** Assert `wb_rst_i` one cycle after a valid sample. Expect no strobe and `komut_o` = 000, with the FSM in IDLE.
- **Macro undefined.** gnss 40, altimetre 20, target 30 → fused 30, HOLD, `fault_o` = 0 permanently.
